// File: rtl/div_seq_pkg.sv
// Shared ALU package: operand width, saturation limit, iteration count and the sequencer state type.
package div_seq_pkg;

   localparam int unsigned ALU_WIDTH   = 11;
   localparam int unsigned ALU_MAX_VAL = 999;
   // Quotient bits needed to cover magnitudes up to ALU_MAX_VAL: ceil(log2(999+1)).
   localparam int unsigned ALU_ITER    = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation of one operand to [-MAX_VAL, MAX_VAL].
module sat_clamp
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = ALU_WIDTH,
   parameter int unsigned MAX_VAL = ALU_MAX_VAL
) (
   input  logic signed [WIDTH-1:0] in_val,
   output logic signed [WIDTH-1:0] out_val
);

   localparam logic signed [WIDTH-1:0] HI = WIDTH'(MAX_VAL);
   localparam logic signed [WIDTH-1:0] LO = -HI;

   // Pass in-range values through, pin the rest to the nearest limit.
   always_comb begin
      out_val = in_val;
      if (in_val > HI) begin
         out_val = HI;
      end else if (in_val < LO) begin
         out_val = LO;
      end
   end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: clamps operands, runs restoring division on magnitudes,
// then restores signs (quotient truncates toward zero, remainder follows the dividend).
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = ALU_WIDTH,
   parameter int unsigned MAX_VAL = ALU_MAX_VAL
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] acc,
   input  logic signed [WIDTH-1:0] arg1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] quot,
   output logic signed [WIDTH-1:0] rem,
   output logic                    div_zero
);

   localparam int unsigned ITER  = ALU_ITER;
   localparam int unsigned CNT_W = $clog2(ITER);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ITER-1:0]         dvs_mag_q, dvs_mag_d;
   logic [ITER-1:0]         q_sr_q, q_sr_d;
   logic [ITER-1:0]         rem_sr_q, rem_sr_d;
   logic                    q_neg_q, q_neg_d;
   logic                    r_neg_q, r_neg_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [WIDTH-1:0]        quot_q, quot_d;
   logic [WIDTH-1:0]        rem_q, rem_d;
   logic                    div_zero_q, div_zero_d;

   logic signed [WIDTH-1:0] acc_c;
   logic signed [WIDTH-1:0] arg_c;
   logic                    acc_neg;
   logic                    arg_neg;
   logic [ITER-1:0]         acc_mag;
   logic [ITER-1:0]         arg_mag;
   logic [ITER:0]           trial;
   logic [ITER-1:0]         step_q;
   logic [ITER-1:0]         step_rem;
   logic [WIDTH-1:0]        q_ext;
   logic [WIDTH-1:0]        r_ext;

   sat_clamp #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_clamp_acc (
      .in_val  (acc),
      .out_val (acc_c)
   );

   sat_clamp #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_clamp_arg (
      .in_val  (arg1),
      .out_val (arg_c)
   );

   // Sign and magnitude of the clamped operands; magnitudes fit in ITER bits after clamping.
   always_comb begin
      acc_neg = acc_c[WIDTH-1];
      arg_neg = arg_c[WIDTH-1];
      acc_mag = ITER'(acc_neg ? -acc_c : acc_c);
      arg_mag = ITER'(arg_neg ? -arg_c : arg_c);
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial = {rem_sr_q, q_sr_q[ITER-1]};
      if (trial >= {1'b0, dvs_mag_q}) begin
         step_rem = ITER'(trial - {1'b0, dvs_mag_q});
         step_q   = {q_sr_q[ITER-2:0], 1'b1};
      end else begin
         step_rem = trial[ITER-1:0];
         step_q   = {q_sr_q[ITER-2:0], 1'b0};
      end
      q_ext = WIDTH'(step_q);
      r_ext = WIDTH'(step_rem);
   end

   // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvs_mag_d   = dvs_mag_q;
      q_sr_d      = q_sr_q;
      rem_sr_d    = rem_sr_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               q_neg_d    = acc_neg ^ arg_neg;
               r_neg_d    = acc_neg;
               dvs_mag_d  = arg_mag;
               if (arg_mag == '0) begin
                  // Zero divisor saturates toward the dividend's sign and skips CALC.
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  div_zero_d  = 1'b1;
                  rem_d       = '0;
                  if (acc_mag == '0) begin
                     quot_d = '0;
                  end else if (acc_neg) begin
                     quot_d = WIDTH'(0) - WIDTH'(MAX_VAL);
                  end else begin
                     quot_d = WIDTH'(MAX_VAL);
                  end
               end else begin
                  state_d  = CALC;
                  cnt_d    = '0;
                  q_sr_d   = acc_mag;
                  rem_sr_d = '0;
               end
            end
         end
         CALC: begin
            q_sr_d   = step_q;
            rem_sr_d = step_rem;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
               // Last quotient bit: apply signs and present the result.
               state_d     = DONE;
               out_valid_d = 1'b1;
               div_zero_d  = 1'b0;
               quot_d      = q_neg_q ? (WIDTH'(0) - q_ext) : q_ext;
               rem_d       = r_neg_q ? (WIDTH'(0) - r_ext) : r_ext;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers; reset abandons any calculation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvs_mag_q   <= '0;
         q_sr_q      <= '0;
         rem_sr_q    <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvs_mag_q   <= dvs_mag_d;
         q_sr_q      <= q_sr_d;
         rem_sr_q    <= rem_sr_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quot      = quot_q;
   assign rem       = rem_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected results built from a behavioural model.
module tb_div_seq;

   localparam int W  = 11;
   localparam int MV = 999;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] acc = '0;
   logic signed [W-1:0] arg1 = '0;
   logic                in_ready;
   logic                out_valid;
   logic signed [W-1:0] quot;
   logic signed [W-1:0] rem;
   logic                div_zero;

   typedef struct {
      logic signed [W-1:0] q;
      logic signed [W-1:0] r;
      logic                dz;
      int                  lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic signed [W-1:0] last_q = '0;
   logic signed [W-1:0] last_r = '0;

   div_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc       (acc),
      .arg1      (arg1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   function automatic int clampv(input int v);
      if (v > MV) return MV;
      if (v < -MV) return -MV;
      return v;
   endfunction

   // Behavioural model: clamp, then language division (truncating, remainder follows dividend).
   task automatic push_exp(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      exp_t e;
      int   ca;
      int   cb;
      ca = clampv(int'(a));
      cb = clampv(int'(b));
      if (cb == 0) begin
         e.q   = (ca > 0) ? W'(MV) : ((ca < 0) ? W'(-MV) : W'(0));
         e.r   = '0;
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = W'(ca / cb);
         e.r   = W'(ca % cb);
         e.dz  = 1'b0;
         e.lat = 11;
      end
      sb.push_back(e);
   endtask

   // One full transaction: offer, wait for result, hold for `hold` cycles of backpressure, release.
   task automatic do_txn(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input int hold);
      exp_t e;
      int   n;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_ready: got %b expected 1", in_ready);
      end
      acc      = a;
      arg1     = b;
      in_valid = 1'b1;
      push_exp(a, b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         if (n == 5) begin
            checks++;
            if (quot !== last_q || rem !== last_r || in_ready !== 1'b0) begin
               errors++;
               $display("FAIL calc_hold: got q=%0d r=%0d rdy=%b expected q=%0d r=%0d rdy=0",
                        quot, rem, in_ready, last_q, last_r);
            end
         end
         @(posedge clk);
         #1;
         n++;
      end
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin
         errors++;
         $display("FAIL latency (%0d/%0d): got %0d edges expected %0d", a, b, n, e.lat);
      end
      checks++;
      if (quot !== e.q) begin
         errors++;
         $display("FAIL quot (%0d/%0d): got %0d expected %0d", a, b, quot, e.q);
      end
      checks++;
      if (rem !== e.r) begin
         errors++;
         $display("FAIL rem (%0d/%0d): got %0d expected %0d", a, b, rem, e.r);
      end
      checks++;
      if (div_zero !== e.dz) begin
         errors++;
         $display("FAIL div_zero (%0d/%0d): got %b expected %b", a, b, div_zero, e.dz);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         acc      = W'(i + 1);
         arg1     = W'(0);
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.q || rem !== e.r || div_zero !== e.dz) begin
            errors++;
            $display("FAIL backpressure_hold: got v=%b rdy=%b q=%0d r=%0d dz=%b expected v=1 rdy=0 q=%0d r=%0d dz=%b",
                     out_valid, in_ready, quot, rem, div_zero, e.q, e.r, e.dz);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      last_q = e.q;
      last_r = e.r;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 || rem !== '0 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b q=%0d r=%0d dz=%b expected 1 0 0 0 0",
                  in_ready, out_valid, quot, rem, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_signed_div();
      do_txn(W'(7), W'(2), 0);
      do_txn(W'(-7), W'(2), 0);
      do_txn(W'(7), W'(-2), 0);
      do_txn(W'(-7), W'(-2), 0);
      do_txn(W'(999), W'(-1), 0);
      do_txn(W'(0), W'(5), 0);
      do_txn(W'(1), W'(999), 0);
   endtask

   task automatic test_div_zero();
      do_txn(W'(5), W'(0), 0);
      do_txn(W'(-5), W'(0), 0);
      do_txn(W'(0), W'(0), 0);
   endtask

   // 1500 is not representable at 11 bits, so the largest encodable values probe the clamp.
   task automatic test_clamp();
      do_txn(W'(1023), W'(3), 0);
      do_txn(W'(-1024), W'(3), 0);
      do_txn(W'(999), W'(-1024), 0);
   endtask

   task automatic test_backpressure();
      do_txn(W'(100), W'(7), 5);
      do_txn(W'(-42), W'(0), 5);
   endtask

   task automatic test_reset_mid_calc();
      @(negedge clk);
      acc      = W'(500);
      arg1     = W'(7);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 || rem !== '0 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_calc: got rdy=%b v=%b q=%0d r=%0d dz=%b expected 1 0 0 0 0",
                  in_ready, out_valid, quot, rem, div_zero);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_result: got v=%b expected 0", out_valid);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      last_q = '0;
      last_r = '0;
      do_txn(W'(-500), W'(7), 0);
   endtask

   task automatic test_back_to_back();
      logic signed [W-1:0] a;
      logic signed [W-1:0] b;
      for (int i = 0; i < 12; i++) begin
         a = W'($urandom);
         if (i % 4 == 0) b = W'(0);
         else if (i % 3 == 0) b = W'(int'($urandom_range(0, 6)) - 3);
         else b = W'($urandom);
         do_txn(a, b, 0);
      end
   endtask

   initial begin
      test_reset();
      test_signed_div();
      test_div_zero();
      test_clamp();
      test_backpressure();
      test_reset_mid_calc();
      test_back_to_back();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
